// File: rtl/cache_refill_engine.sv
// rtl/cache_refill_engine.sv - miss handler: victim write-back, line fetch and single-pulse fill
module cache_refill_engine #(
    parameter int ADDRESS_WIDTH   = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int TAG_BITS        = 18,
    parameter int INDEX_BITS      = 8,
    parameter int OFFSET_BITS     = 6,
    parameter int LINE_SIZE_BYTES = 64,
    localparam int LINE_SIZE_BITS = 8 * LINE_SIZE_BYTES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic [TAG_BITS-1:0]       i_tag,
    input  logic [INDEX_BITS-1:0]     i_index,
    input  logic                      i_victim_dirty,
    input  logic [TAG_BITS-1:0]       i_victim_tag,
    input  logic [LINE_SIZE_BITS-1:0] i_victim_line,
    output logic                      o_fill_valid,
    output logic [TAG_BITS-1:0]       o_fill_tag,
    output logic [INDEX_BITS-1:0]     o_fill_index,
    output logic [LINE_SIZE_BITS-1:0] o_fill_line,
    output logic                      o_busy,
    output logic                      o_mem_req_valid,
    input  logic                      i_mem_req_ready,
    output logic                      o_mem_we,
    output logic [ADDRESS_WIDTH-1:0]  o_mem_addr,
    output logic [DATA_WIDTH-1:0]     o_mem_wdata,
    input  logic                      i_mem_rdata_valid,
    input  logic [DATA_WIDTH-1:0]     i_mem_rdata
);

    localparam int BEATS      = LINE_SIZE_BITS / DATA_WIDTH;
    localparam int CW         = $clog2(BEATS);
    localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);

    typedef enum logic [2:0] {S_IDLE, S_WB, S_RD_REQ, S_RD_DATA, S_FILL} state_t;

    state_t                    r_state;
    logic [CW-1:0]             r_cnt;
    logic [TAG_BITS-1:0]       r_tag;
    logic [TAG_BITS-1:0]       r_victim_tag;
    logic [INDEX_BITS-1:0]     r_index;
    logic [LINE_SIZE_BITS-1:0] r_victim_line;
    logic [LINE_SIZE_BITS-1:0] r_fill_line;
    logic                      r_mem_req_valid;
    logic                      r_mem_we;
    logic [ADDRESS_WIDTH-1:0]  r_mem_addr;
    logic [DATA_WIDTH-1:0]     r_mem_wdata;

    logic [CW-1:0]             w_next_cnt;
    logic [OFFSET_BITS-1:0]    w_next_off;
    logic                      w_last;

    assign w_next_cnt = r_cnt + CW'(1);
    assign w_next_off = OFFSET_BITS'(w_next_cnt) << BYTE_SHIFT;
    assign w_last     = (r_cnt == CW'(BEATS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_tag           <= '0;
            r_victim_tag    <= '0;
            r_index         <= '0;
            r_victim_line   <= '0;
            r_fill_line     <= '0;
            r_mem_req_valid <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_tag           <= i_tag;
                        r_index         <= i_index;
                        r_victim_tag    <= i_victim_tag;
                        r_victim_line   <= i_victim_line;
                        r_cnt           <= '0;
                        r_mem_req_valid <= 1'b1;
                        // First memory request is preloaded here so it is valid the cycle after accept
                        if (i_victim_dirty) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= {i_victim_tag, i_index, {OFFSET_BITS{1'b0}}};
                            r_mem_wdata <= i_victim_line[DATA_WIDTH-1:0];
                            r_state     <= S_WB;
                        end else begin
                            r_mem_we    <= 1'b0;
                            r_mem_addr  <= {i_tag, i_index, {OFFSET_BITS{1'b0}}};
                            r_mem_wdata <= '0;
                            r_state     <= S_RD_REQ;
                        end
                    end
                end
                S_WB: begin
                    if (i_mem_req_ready) begin
                        if (w_last) begin
                            r_mem_we    <= 1'b0;
                            r_mem_addr  <= {r_tag, r_index, {OFFSET_BITS{1'b0}}};
                            r_mem_wdata <= '0;
                            r_state     <= S_RD_REQ;
                        end else begin
                            r_cnt       <= w_next_cnt;
                            r_mem_addr  <= {r_victim_tag, r_index, w_next_off};
                            r_mem_wdata <= r_victim_line[int'(w_next_cnt)*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                end
                S_RD_REQ: begin
                    if (i_mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_cnt           <= '0;
                        r_state         <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (i_mem_rdata_valid) begin
                        r_fill_line[int'(r_cnt)*DATA_WIDTH +: DATA_WIDTH] <= i_mem_rdata;
                        if (w_last) begin
                            r_state <= S_FILL;
                        end else begin
                            r_cnt <= w_next_cnt;
                        end
                    end
                end
                S_FILL: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready     = (r_state == S_IDLE);
    assign o_busy          = (r_state != S_IDLE);
    assign o_fill_valid    = (r_state == S_FILL);
    assign o_fill_tag      = r_tag;
    assign o_fill_index    = r_index;
    assign o_fill_line     = r_fill_line;
    assign o_mem_req_valid = r_mem_req_valid;
    assign o_mem_we        = r_mem_we;
    assign o_mem_addr      = r_mem_addr;
    assign o_mem_wdata     = r_mem_wdata;

endmodule

// File: tb/tb_cache_refill_engine.sv
// tb/tb_cache_refill_engine.sv - randomized bench with behavioural memory and miss-timing model
module tb_cache_refill_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_req_valid;
    logic         o_req_ready;
    logic [17:0]  i_tag;
    logic [7:0]   i_index;
    logic         i_victim_dirty;
    logic [17:0]  i_victim_tag;
    logic [511:0] i_victim_line;
    logic         o_fill_valid;
    logic [17:0]  o_fill_tag;
    logic [7:0]   o_fill_index;
    logic [511:0] o_fill_line;
    logic         o_busy;
    logic         o_mem_req_valid;
    logic         i_mem_req_ready;
    logic         o_mem_we;
    logic [31:0]  o_mem_addr;
    logic [31:0]  o_mem_wdata;
    logic         i_mem_rdata_valid;
    logic [31:0]  i_mem_rdata;

    cache_refill_engine dut (
        .clk               (clk),
        .rst               (rst),
        .i_req_valid       (i_req_valid),
        .o_req_ready       (o_req_ready),
        .i_tag             (i_tag),
        .i_index           (i_index),
        .i_victim_dirty    (i_victim_dirty),
        .i_victim_tag      (i_victim_tag),
        .i_victim_line     (i_victim_line),
        .o_fill_valid      (o_fill_valid),
        .o_fill_tag        (o_fill_tag),
        .o_fill_index      (o_fill_index),
        .o_fill_line       (o_fill_line),
        .o_busy            (o_busy),
        .o_mem_req_valid   (o_mem_req_valid),
        .i_mem_req_ready   (i_mem_req_ready),
        .o_mem_we          (o_mem_we),
        .o_mem_addr        (o_mem_addr),
        .o_mem_wdata       (o_mem_wdata),
        .i_mem_rdata_valid (i_mem_rdata_valid),
        .i_mem_rdata       (i_mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // memory behaviour knobs
    int wb_stall_beat = -1;
    int wb_stall_len  = 0;
    int rd_stall_len  = 0;
    bit rand_wait     = 0;
    bit rand_gap      = 0;
    int fixed_gap     = 0;
    bit fixed_data    = 0;
    bit stray         = 0;

    // per-miss observations
    int           stall_left = -1;
    int           wr_seen, rd_reqs, beats_left, gap_left, beat_idx;
    int           stall_total, gap_total, fill_cnt, fill_cyc;
    int           first_ready_cyc = -1;
    int           watch_from = 0;
    logic [31:0]  wr_addr[$];
    logic [31:0]  wr_data[$];
    logic [31:0]  rd_addr;
    logic [511:0] exp_line;
    bit           prev_stalled;
    logic [31:0]  prev_addr, prev_wdata;
    logic         prev_we;

    logic [17:0]  cur_tag, cur_vtag;
    logic [7:0]   cur_index;
    bit           cur_dirty;
    logic [511:0] cur_vline;
    int           cur_t;

    function automatic logic [31:0] line_addr(logic [17:0] t, logic [7:0] ix, int k);
        return (32'(t) << 14) | (32'(ix) << 6) | 32'(k * 4);
    endfunction

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    // One clock of the memory model; returns at a falling edge with inputs set for the next rising edge.
    task automatic cycle();
        int s;
        @(negedge clk);
        if (prev_stalled) begin
            check("stall_valid", o_mem_req_valid, 1'b1);
            check("stall_addr", o_mem_addr, prev_addr);
            check("stall_wdata", o_mem_wdata, prev_wdata);
            check("stall_we", o_mem_we, prev_we);
        end
        if (o_fill_valid) begin
            fill_cnt++;
            fill_cyc = cyc;
        end
        if (o_req_ready && first_ready_cyc < 0 && cyc >= watch_from) first_ready_cyc = cyc;
        i_mem_rdata_valid = 1'b0;
        i_mem_rdata = $urandom;
        if (beats_left > 0) begin
            if (gap_left > 0) begin
                gap_left--;
                gap_total++;
            end else begin
                i_mem_rdata_valid = 1'b1;
                if (fixed_data) i_mem_rdata = 32'h1000 + beat_idx;
                exp_line[beat_idx*32 +: 32] = i_mem_rdata;
                beat_idx++;
                beats_left--;
                gap_left = rand_gap ? int'($urandom_range(0, 2)) : fixed_gap;
            end
        end else if (stray) begin
            i_mem_rdata_valid = 1'b1;
            stray = 0;
        end
        i_mem_req_ready = 1'b0;
        if (o_mem_req_valid) begin
            if (stall_left < 0) begin
                s = 0;
                if (o_mem_we && wr_seen == wb_stall_beat) s = wb_stall_len;
                if (!o_mem_we) s = rd_stall_len;
                if (rand_wait) s += int'($urandom_range(0, 2));
                stall_left = s;
            end
            if (stall_left > 0) begin
                stall_left--;
                stall_total++;
            end else begin
                i_mem_req_ready = 1'b1;
                stall_left = -1;
                if (o_mem_we) begin
                    wr_addr.push_back(o_mem_addr);
                    wr_data.push_back(o_mem_wdata);
                    wr_seen++;
                end else begin
                    rd_reqs++;
                    rd_addr = o_mem_addr;
                    beats_left = 16;
                    beat_idx = 0;
                    gap_left = rand_gap ? int'($urandom_range(0, 2)) : 0;
                end
            end
        end
        prev_stalled = o_mem_req_valid && !i_mem_req_ready;
        prev_addr  = o_mem_addr;
        prev_wdata = o_mem_wdata;
        prev_we    = o_mem_we;
    endtask

    task automatic mem_clear();
        beats_left = 0;
        gap_left = 0;
        stall_left = -1;
        prev_stalled = 0;
        i_mem_req_ready = 1'b0;
        i_mem_rdata_valid = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", o_req_ready, 1'b1);
        check("rst_busy", o_busy, 1'b0);
        check("rst_fill_valid", o_fill_valid, 1'b0);
        check("rst_mem_valid", o_mem_req_valid, 1'b0);
        check("rst_mem_we", o_mem_we, 1'b0);
        check("rst_mem_addr", o_mem_addr, 32'h0);
        check("rst_mem_wdata", o_mem_wdata, 32'h0);
        check("rst_fill_tag", o_fill_tag, 18'h0);
        check("rst_fill_index", o_fill_index, 8'h0);
        check("rst_fill_line", o_fill_line, 512'h0);
    endtask

    task automatic start_miss(input logic [17:0] t, input logic [7:0] ix, input bit d,
                              input logic [17:0] vt, input logic [511:0] vl);
        int g;
        cur_tag = t; cur_index = ix; cur_dirty = d; cur_vtag = vt; cur_vline = vl;
        wr_addr.delete(); wr_data.delete();
        wr_seen = 0; rd_reqs = 0; stall_total = 0; gap_total = 0; fill_cnt = 0;
        beat_idx = 0; exp_line = '0;
        i_req_valid = 1'b1; i_tag = t; i_index = ix; i_victim_dirty = d;
        i_victim_tag = vt; i_victim_line = vl;
        g = 0;
        while (!o_req_ready && g < 300) begin
            cycle();
            g++;
        end
        check("accept_ready", o_req_ready, 1'b1);
        cur_t = cyc;
        cycle();
        i_req_valid = 1'b0; i_tag = $urandom; i_index = $urandom; i_victim_dirty = $urandom;
        i_victim_tag = $urandom; i_victim_line = rand_line();
    endtask

    task automatic finish_miss(input int exp_lat, output int f);
        int g;
        g = 0;
        while (fill_cnt == 0 && g < 400) begin
            cycle();
            g++;
        end
        check("fill_seen", fill_cnt, 1);
        f = fill_cyc;
        check("fill_latency", fill_cyc - cur_t, 18 + (cur_dirty ? 16 : 0) + stall_total + gap_total);
        if (exp_lat > 0) check("fill_latency_abs", fill_cyc - cur_t, exp_lat);
        check("fill_tag", o_fill_tag, cur_tag);
        check("fill_index", o_fill_index, cur_index);
        check("fill_line", o_fill_line, exp_line);
        check("wb_count", wr_addr.size(), cur_dirty ? 16 : 0);
        for (int k = 0; k < wr_addr.size() && k < 16; k++) begin
            check("wb_addr", wr_addr[k], line_addr(cur_vtag, cur_index, k));
            check("wb_data", wr_data[k], cur_vline[k*32 +: 32]);
        end
        check("rd_count", rd_reqs, 1);
        check("rd_addr", rd_addr, line_addr(cur_tag, cur_index, 0));
        cycle();
        check("fill_pulse", o_fill_valid, 1'b0);
        check("fill_hold_line", o_fill_line, exp_line);
        check("fill_hold_tag", o_fill_tag, cur_tag);
    endtask

    initial begin
        int f, f2, tb_acc, g;
        logic [511:0] vl, last_line;
        rst = 1'b1;
        i_req_valid = 1'b0; i_tag = '0; i_index = '0; i_victim_dirty = 1'b0;
        i_victim_tag = '0; i_victim_line = '0;
        i_mem_req_ready = 1'b0; i_mem_rdata_valid = 1'b0; i_mem_rdata = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        cycle();

        // clean miss, zero-wait memory
        fixed_data = 1;
        start_miss(18'h2AAAA, 8'h5A, 1'b0, 18'h3FFFF, rand_line());
        finish_miss(18, f);
        check("clean_rd_addr", rd_addr, 32'hAAAA9680);
        check("clean_word0", o_fill_line[31:0], 32'h1000);
        check("clean_word15", o_fill_line[511:480], 32'h100F);

        // dirty miss, victim words 0xA0+k
        for (int k = 0; k < 16; k++) vl[k*32 +: 32] = 32'hA0 + k;
        start_miss(18'h12345, 8'h03, 1'b1, 18'h00001, vl);
        finish_miss(34, f);
        if (wr_addr.size() == 16) begin
            check("dirty_addr_first", wr_addr[0], 32'h000040C0);
            check("dirty_addr_last", wr_addr[15], 32'h000040FC);
            check("dirty_data_last", wr_data[15], 32'hAF);
        end
        fixed_data = 0;

        // back-pressure on write beat 5 and on the read request
        wb_stall_beat = 5; wb_stall_len = 3; rd_stall_len = 3;
        start_miss($urandom, $urandom, 1'b1, $urandom, rand_line());
        finish_miss(40, f);
        wb_stall_beat = -1; wb_stall_len = 0; rd_stall_len = 0;

        // stray read beat in IDLE, then 2-cycle gaps between beats
        last_line = o_fill_line;
        stray = 1;
        cycle();
        cycle();
        check("stray_hold", o_fill_line, last_line);
        fixed_gap = 2;
        start_miss($urandom, $urandom, 1'b0, $urandom, rand_line());
        finish_miss(48, f);
        fixed_gap = 0;

        // reset after read beat 7
        start_miss($urandom, $urandom, 1'b0, $urandom, rand_line());
        g = 0;
        while (beat_idx < 8 && g < 200) begin
            cycle();
            g++;
        end
        check("rst_reach_beat7", beat_idx, 8);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        mem_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycle();
        check("post_rst_mem_valid", o_mem_req_valid, 1'b0);
        check("post_rst_busy", o_busy, 1'b0);
        check("post_rst_no_fill", fill_cnt, 0);
        start_miss($urandom, $urandom, 1'b0, $urandom, rand_line());
        finish_miss(18, f);

        // request held while busy, accepted right after the fill pulse
        start_miss($urandom, $urandom, 1'b1, $urandom, rand_line());
        first_ready_cyc = -1;
        watch_from = cyc;
        i_req_valid = 1'b1; i_tag = $urandom; i_index = $urandom; i_victim_dirty = 1'b0;
        i_victim_tag = $urandom; i_victim_line = rand_line();
        finish_miss(34, f);
        check("busy_first_ready", first_ready_cyc, f + 1);
        start_miss(i_tag, i_index, i_victim_dirty, i_victim_tag, i_victim_line);
        tb_acc = cur_t;
        check("b2b_accept", tb_acc, f + 1);
        finish_miss(18, f2);

        // randomized misses with random waits and gaps
        rand_wait = 1; rand_gap = 1;
        for (int n = 0; n < 8; n++) begin
            stray = ($urandom_range(0, 1) == 1);
            start_miss($urandom, $urandom, ($urandom_range(0, 1) == 1), $urandom, rand_line());
            finish_miss(0, f);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
